// File: rtl/proc_core_param.sv
// proc_core_param: parametrised multicycle core, R7 as PC, A/G datapath,
// hardware stack and ready/ack data-memory port.
module proc_core_param #(
  parameter int DATA_W = 16,
  parameter int IADDR_W = 8,
  parameter int DADDR_W = 7,
  parameter logic [DADDR_W-1:0] SP_INIT = DADDR_W'(5)
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               run,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic [9:0]         imem_data,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  output logic               done,
  output logic               halted,
  output logic [DATA_W-1:0]  pc,
  output logic [DADDR_W-1:0] sp,
  output logic [DATA_W-1:0]  bus_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EX1   = 3'd2;
  localparam logic [2:0] S_EX2   = 3'd3;
  localparam logic [2:0] S_EX3   = 3'd4;
  localparam logic [2:0] S_MEM   = 3'd5;
  localparam logic [2:0] S_HALT  = 3'd6;

  localparam logic [3:0] OP_MV   = 4'd0;
  localparam logic [3:0] OP_MVI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_LD   = 4'd4;
  localparam logic [3:0] OP_ST   = 4'd5;
  localparam logic [3:0] OP_MVNZ = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_PUSH = 4'd8;
  localparam logic [3:0] OP_POP  = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd10;

  localparam logic [DATA_W-1:0]  ONE_D = DATA_W'(1);
  localparam logic [DADDR_W-1:0] ONE_A = DADDR_W'(1);

  logic [2:0]        state, nxt, fin;
  logic [9:0]        ir;
  logic [DATA_W-1:0] rf [8];
  logic [DATA_W-1:0] a, g;
  logic [DADDR_W-1:0] sp_q;
  logic [3:0]        op;
  logic [2:0]        rx, ry;
  logic [DATA_W-1:0] rx_val, ry_val, imm;
  logic              alu, is_ld, is_st, is_push, is_pop;

  function automatic logic mem_op(input logic [3:0] o);
    return o == OP_LD || o == OP_ST ||
           o == OP_PUSH || o == OP_POP;
  endfunction

  assign op      = ir[9:6];
  assign rx      = ir[5:3];
  assign ry      = ir[2:0];
  assign rx_val  = rf[rx];
  assign ry_val  = rf[ry];
  assign imm     = DATA_W'(imem_data);
  assign alu     = op == OP_ADD || op == OP_SUB || op == OP_SLT;
  assign is_ld   = op == OP_LD;
  assign is_st   = op == OP_ST;
  assign is_push = op == OP_PUSH;
  assign is_pop  = op == OP_POP;

  assign imem_addr = rf[7][IADDR_W-1:0];
  assign pc        = rf[7];
  assign sp        = sp_q;
  assign halted    = state == S_HALT;
  assign fin       = run ? S_FETCH : S_IDLE;

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (run) nxt = S_FETCH;
      S_FETCH: nxt = mem_op(imem_data[9:6]) ? S_MEM : S_EX1;
      S_EX1: begin
        if (alu)                nxt = S_EX2;
        else if (op == OP_HALT) nxt = S_HALT;
        else                    nxt = fin;
      end
      S_EX2:  nxt = S_EX3;
      S_EX3:  nxt = fin;
      S_MEM:  if (dmem_ack) nxt = fin;
      S_HALT: nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
  end

  // done and the memory strobes decode straight from registered state
  always_comb begin
    done = 1'b0;
    unique case (state)
      S_EX1:   done = !alu;
      S_EX3:   done = 1'b1;
      S_MEM:   done = dmem_ack;
      default: done = 1'b0;
    endcase
  end

  assign dmem_req   = state == S_MEM;
  assign dmem_we    = dmem_req && (is_st || is_push);
  assign dmem_wdata = dmem_we ? rx_val : '0;

  always_comb begin
    dmem_addr = '0;
    if (dmem_req) begin
      unique case (1'b1)
        is_push: dmem_addr = sp_q - ONE_A;
        is_pop:  dmem_addr = sp_q;
        default: dmem_addr = ry_val[DADDR_W-1:0];
      endcase
    end
  end

  always_comb begin
    bus_out = '0;
    unique case (state)
      S_FETCH: bus_out = imm;
      S_EX1: begin
        unique case (op)
          OP_MV, OP_MVNZ:         bus_out = ry_val;
          OP_MVI:                 bus_out = imm;
          OP_ADD, OP_SUB, OP_SLT: bus_out = rx_val;
          default:                bus_out = '0;
        endcase
      end
      S_EX2: bus_out = ry_val;
      S_EX3: bus_out = g;
      S_MEM: begin
        if (is_ld || is_pop) bus_out = dmem_ack ? dmem_rdata : '0;
        else                 bus_out = rx_val;
      end
      default: bus_out = '0;
    endcase
  end

  // later assignments to rf[rx] override the R7 increment on a jump
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      a     <= '0;
      g     <= '0;
      ir    <= '0;
      sp_q  <= SP_INIT;
      state <= S_IDLE;
    end else begin
      state <= nxt;
      unique case (state)
        S_FETCH: begin
          ir    <= imem_data;
          rf[7] <= rf[7] + ONE_D;
        end
        S_EX1: begin
          unique case (op)
            OP_MV: rf[rx] <= ry_val;
            OP_MVI: begin
              rf[7]  <= rf[7] + ONE_D;
              rf[rx] <= imm;
            end
            OP_MVNZ: if (g != '0) rf[rx] <= ry_val;
            OP_ADD, OP_SUB, OP_SLT: a <= rx_val;
            default: ;
          endcase
        end
        S_EX2: begin
          unique case (op)
            OP_ADD:  g <= a + ry_val;
            OP_SUB:  g <= a - ry_val;
            OP_SLT:  g <= DATA_W'(a < ry_val);
            default: ;
          endcase
        end
        S_EX3: rf[rx] <= g;
        S_MEM: begin
          if (dmem_ack) begin
            if (is_ld || is_pop) rf[rx] <= dmem_rdata;
            if (is_push) sp_q <= sp_q - ONE_A;
            if (is_pop)  sp_q <= sp_q + ONE_A;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_core_param.sv
// tb_proc_core_param: directed programs against proc_core_param with a
// ROM model and a latency-programmable data memory.
`timescale 1ns/1ps
module tb_proc_core_param;

  localparam int DW = 16;
  localparam int IW = 8;
  localparam int AW = 7;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          run = 1'b0;
  logic [IW-1:0] imem_addr;
  logic [9:0]    imem_data;
  logic          dmem_req, dmem_we, dmem_ack;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata;
  logic          done, halted;
  logic [DW-1:0] pc, bus_out;
  logic [AW-1:0] sp;

  logic [9:0]    rom [256];
  logic [DW-1:0] mem [128];
  logic [AW-1:0] wa [4];
  logic [DW-1:0] wd [4];
  int ack_lat = 0;
  int wcnt = 0;
  int wr_cnt = 0;
  int errors = 0;
  int checks = 0;

  proc_core_param dut (
    .clock(clock), .resetn(resetn), .run(run),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .done(done), .halted(halted), .pc(pc), .sp(sp),
    .bus_out(bus_out)
  );

  always #5 clock = ~clock;

  assign imem_data  = rom[imem_addr];
  assign dmem_rdata = mem[dmem_addr];
  assign dmem_ack   = dmem_req && (wcnt >= ack_lat);

  always @(posedge clock) begin
    if (dmem_req && !dmem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (dmem_req && dmem_we && dmem_ack) begin
      mem[dmem_addr] <= dmem_wdata;
      wa[wr_cnt % 4] <= dmem_addr;
      wd[wr_cnt % 4] <= dmem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  function automatic logic [9:0] ins(input int op, input int x, input int y);
    return {op[3:0], x[2:0], y[2:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = ins(10, 0, 0);
  endtask

  task automatic do_reset();
    run = 1'b0;
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 64);
    if (!done) chk(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!halted && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(halted), 32'd1);
  endtask

  initial begin
    logic [8:0] dbits;
    int cnt, dat, w0;

    // scenario 1: MVI/MVI/ADD timing, then HALT
    clear_rom();
    rom[0] = ins(1, 0, 0); rom[1] = 10'd5;
    rom[2] = ins(1, 1, 0); rom[3] = 10'd3;
    rom[4] = ins(2, 0, 1); rom[5] = ins(10, 0, 0);
    do_reset();
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_we", 32'(dmem_we), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_sp", 32'(sp), 5);
    chk("rst_bus", 32'(bus_out), 0);
    chk("rst_addr", 32'(dmem_addr), 0);
    chk("rst_wdata", 32'(dmem_wdata), 0);
    run = 1'b1;
    dbits = '0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      dbits[c] = done;
      if (c == 8) chk("s1_pc", 32'(pc), 5);
    end
    chk("s1_done_cycles", 32'(dbits), 32'h114);
    tick();
    chk("s1_r0", 32'(dut.rf[0]), 8);
    chk("s1_r1", 32'(dut.rf[1]), 3);
    wait_halt("s1_halt");
    chk("s1_halt_pc", 32'(pc), 6);
    run = 1'b0;
    repeat (3) tick();
    run = 1'b1;
    repeat (3) tick();
    chk("halt_sticky", 32'(halted), 1);
    chk("halt_pc", 32'(pc), 6);
    chk("halt_done", 32'(done), 0);

    // scenario 2: SUB wrap, MVNZ, SLT
    clear_rom();
    rom[0] = ins(1, 0, 0); rom[1] = 10'd0;
    rom[2] = ins(1, 1, 0); rom[3] = 10'd1;
    rom[4] = ins(3, 0, 1); rom[5] = ins(6, 2, 1);
    rom[6] = ins(7, 3, 1); rom[7] = ins(10, 0, 0);
    do_reset();
    run = 1'b1;
    wait_done("s2_d1");
    wait_done("s2_d2");
    wait_done("s2_d3");
    tick();
    chk("sub_r0", 32'(dut.rf[0]), 32'hFFFF);
    chk("sub_g", 32'(dut.g), 32'hFFFF);
    wait_halt("s2_halt");
    chk("mvnz_r2", 32'(dut.rf[2]), 1);
    chk("slt_r3", 32'(dut.rf[3]), 1);
    chk("slt_g", 32'(dut.g), 1);

    // scenario 3: ST with 3-cycle ack, LD with immediate ack
    clear_rom();
    rom[0] = ins(1, 0, 0); rom[1] = 10'h2A5;
    rom[2] = ins(1, 1, 0); rom[3] = 10'h011;
    rom[4] = ins(5, 0, 1); rom[5] = ins(4, 3, 1);
    rom[6] = ins(10, 0, 0);
    ack_lat = 2;
    do_reset();
    run = 1'b1;
    cnt = 0;
    while (!dmem_req && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("st_req_seen", 32'(dmem_req), 1);
    cnt = 0;
    dat = -1;
    while (dmem_req && cnt < 10) begin
      chk("st_addr", 32'(dmem_addr), 32'h11);
      chk("st_wdata", 32'(dmem_wdata), 32'h2A5);
      chk("st_we", 32'(dmem_we), 1);
      if (done) dat = cnt;
      cnt++;
      tick();
    end
    chk("st_req_cycles", 32'(cnt), 3);
    chk("st_done_at", 32'(dat), 2);
    ack_lat = 0;
    wait_halt("s3_halt");
    chk("ld_r3", 32'(dut.rf[3]), 32'h2A5);
    chk("st_mem", 32'(mem[17]), 32'h2A5);

    // scenario 4: stack
    clear_rom();
    rom[0] = ins(1, 0, 0); rom[1] = 10'h0A;
    rom[2] = ins(1, 1, 0); rom[3] = 10'h0B;
    rom[4] = ins(8, 0, 0); rom[5] = ins(8, 1, 0);
    rom[6] = ins(9, 2, 0); rom[7] = ins(9, 3, 0);
    rom[8] = ins(10, 0, 0);
    ack_lat = 1;
    do_reset();
    w0 = wr_cnt;
    run = 1'b1;
    for (int k = 0; k < 4; k++) wait_done("s4_done");
    tick();
    chk("push_sp", 32'(sp), 3);
    chk("push1_addr", 32'(wa[w0 % 4]), 4);
    chk("push1_data", 32'(wd[w0 % 4]), 32'h0A);
    chk("push2_addr", 32'(wa[(w0 + 1) % 4]), 3);
    chk("push2_data", 32'(wd[(w0 + 1) % 4]), 32'h0B);
    wait_halt("s4_halt");
    chk("pop_r2", 32'(dut.rf[2]), 32'h0B);
    chk("pop_r3", 32'(dut.rf[3]), 32'h0A);
    chk("pop_sp", 32'(sp), 5);

    // scenario 5: MVI R7 jump loop
    clear_rom();
    rom[0] = ins(1, 7, 0); rom[1] = 10'd0;
    ack_lat = 0;
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("jmp_pc", 32'(pc), (c % 2 == 0) ? 32'd1 : 32'd0);
    end
    chk("jmp_halted", 32'(halted), 0);

    // scenario 5b: reset during a stalled PUSH
    clear_rom();
    rom[0] = ins(1, 0, 0); rom[1] = 10'h0A;
    rom[2] = ins(8, 0, 0); rom[3] = ins(10, 0, 0);
    ack_lat = 5;
    do_reset();
    run = 1'b1;
    cnt = 0;
    while (!dmem_req && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("push_req_seen", 32'(dmem_req), 1);
    tick();
    tick();
    w0 = wr_cnt;
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_req", 32'(dmem_req), 0);
    chk("mid_rst_sp", 32'(sp), 5);
    chk("mid_rst_r0", 32'(dut.rf[0]), 0);
    chk("mid_rst_pc", 32'(pc), 0);
    chk("mid_rst_bus", 32'(bus_out), 0);
    tick();
    chk("mid_rst_nowrite", 32'(wr_cnt), 32'(w0));
    resetn = 1'b1;
    ack_lat = 0;

    // scenario 6: drop run during ADD
    clear_rom();
    rom[0] = ins(1, 0, 0); rom[1] = 10'd5;
    rom[2] = ins(1, 1, 0); rom[3] = 10'd3;
    rom[4] = ins(2, 0, 1);
    rom[5] = ins(1, 2, 0); rom[6] = 10'd7;
    rom[7] = ins(10, 0, 0);
    do_reset();
    run = 1'b1;
    wait_done("s6_d1");
    wait_done("s6_d2");
    tick();
    tick();
    run = 1'b0;
    tick();
    tick();
    chk("drop_ex3_done", 32'(done), 1);
    tick();
    chk("drop_r0", 32'(dut.rf[0]), 8);
    chk("drop_pc", 32'(pc), 5);
    tick();
    tick();
    chk("idle_pc", 32'(pc), 5);
    chk("idle_done", 32'(done), 0);
    chk("idle_bus", 32'(bus_out), 0);
    chk("idle_r2", 32'(dut.rf[2]), 0);
    run = 1'b1;
    wait_done("s6_resume");
    tick();
    chk("resume_r2", 32'(dut.rf[2]), 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
